// File: rtl/result_capture_pkg.sv
// ============================================================================
// result_capture_pkg -- shared occupancy-state encoding and default sizes
// Revision: 1.0
// ============================================================================
`default_nettype none

package result_capture_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

`default_nettype wire

// File: rtl/capture_fifo_mem.sv
// ============================================================================
// capture_fifo_mem -- FIFO storage array with one write port and a registered
// read port; only the read register is reset, the array itself is not.
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // A read and write to the same slot in one cycle returns the old contents,
    // which is what a pop-while-full needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_capture.sv
// ============================================================================
// result_capture -- captures a non-backpressured sample stream into a circular
// FIFO, tracking occupancy, a sticky overflow flag and a running checksum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_capture
    import result_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   validi,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   clr,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [WIDTH-1:0]       checksum
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    occ_state_t      r_state;
    occ_state_t      w_state_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_overflow;
    logic [WIDTH-1:0] r_checksum;
    logic            r_rd_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // A clear cycle ignores every other input, so it gates pop/push here too.
    always_comb begin
        w_pop  = rd_en && (r_state != OCC_EMPTY) && !clr;
        w_push = validi && ((r_state != OCC_FULL) || w_pop) && !clr;
        w_drop = validi && (r_state == OCC_FULL) && !w_pop && !clr;

        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end

        w_state_nxt = OCC_PARTIAL;
        if (w_count_nxt == '0) begin
            w_state_nxt = OCC_EMPTY;
        end else if (w_count_nxt == CW'(DEPTH)) begin
            w_state_nxt = OCC_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state    <= OCC_EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_checksum <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_pop;
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_checksum <= r_checksum + data_in;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    capture_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_en   (w_pop),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign empty    = (r_state == OCC_EMPTY);
    assign full     = (r_state == OCC_FULL);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign checksum = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_result_capture.sv
// ============================================================================
// tb_result_capture -- directed scenarios plus randomized traffic against a
// queue-based reference model of the capture FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_capture;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       validi = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       clr = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] checksum;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_sum = 8'h00;
    logic [7:0] m_rdd = 8'h00;
    logic       m_rdv = 1'b0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    result_capture #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .validi   (validi),
        .data_in  (data_in),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .checksum (checksum)
    );

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic rr, input logic c);
        logic pop;
        logic acc;
        rst = r; validi = v; data_in = d; rd_en = rr; clr = c;
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete(); m_sum = 8'h00; m_ovf = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
        end else if (c) begin
            m_q.delete(); m_sum = 8'h00; m_ovf = 1'b0; m_rdv = 1'b0;
        end else begin
            pop = rr && (m_q.size() > 0);
            acc = v && ((m_q.size() < DEPTH) || pop);
            m_rdv = pop;
            if (pop) m_rdd = m_q.pop_front();
            if (acc) begin
                m_q.push_back(d);
                m_sum = m_sum + d;
            end else if (v) begin
                m_ovf = 1'b1;
            end
        end
        rst = 1'b0; validi = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({rd_data, rd_valid, count, empty, full, overflow, checksum} !== {8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_state: got rd_data=%h rd_valid=%b count=%0d empty=%b full=%b ovf=%b sum=%h want 00 0 0 1 0 0 00",
                     rd_data, rd_valid, count, empty, full, overflow, checksum);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, exp_d[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin
                n_errors++;
                $display("FAIL basic_pop%0d: got valid=%b data=%h want 1 %h", i, rd_valid, rd_data, exp_d[i]);
            end
        end
        n_checks++;
        if (checksum !== 8'h66 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_end: got sum=%h empty=%b want 66 1", checksum, empty);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            n_errors++;
            $display("FAIL ovf_full: got full=%b count=%0d want 1 8", full, count);
        end
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || checksum !== 8'h24) begin
            n_errors++;
            $display("FAIL ovf_drop: got ovf=%b count=%0d sum=%h want 1 8 24", overflow, count, checksum);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                n_errors++;
                $display("FAIL ovf_pop%0d: got valid=%b data=%h want 1 %h", i, rd_valid, rd_data, 8'(i));
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: got ovf=%b empty=%b want 1 1", overflow, empty);
        end
    endtask

    task automatic test_full_simul();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h10 || count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_simul: got valid=%b data=%h count=%0d ovf=%b full=%b want 1 10 8 0 1",
                     rd_valid, rd_data, count, overflow, full);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_data !== 8'hAA || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL full_simul_last: got data=%h empty=%b want aa 1", rd_data, empty);
        end
    endtask

    task automatic test_empty_rdwr();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 4'd1) begin
            n_errors++;
            $display("FAIL empty_rdwr: got valid=%b count=%0d want 0 1", rd_valid, count);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
            n_errors++;
            $display("FAIL empty_rdwr_pop: got valid=%b data=%h want 1 5a", rd_valid, rd_data);
        end
    endtask

    task automatic test_checksum_clr();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        n_checks++;
        if (checksum !== 8'h10) begin
            n_errors++;
            $display("FAIL sum_wrap: got %h want 10", checksum);
        end
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || checksum !== 8'h10) begin
            n_errors++;
            $display("FAIL pre_clr: got ovf=%b sum=%h want 1 10", overflow, checksum);
        end
        step(1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
        n_checks++;
        if (count !== 4'd0 || checksum !== 8'h00 || overflow !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clr: got count=%0d sum=%h ovf=%b empty=%b valid=%b want 0 00 0 1 0",
                     count, checksum, overflow, empty, rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        n_checks++;
        if ({rd_data, rd_valid, count, empty, full, overflow, checksum} !== {8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL mid_reset: got rd_data=%h rd_valid=%b count=%0d empty=%b full=%b ovf=%b sum=%h want 00 0 0 1 0 0 00",
                     rd_data, rd_valid, count, empty, full, overflow, checksum);
        end
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
            n_errors++;
            $display("FAIL mid_reset_pop: got valid=%b data=%h want 1 77", rd_valid, rd_data);
        end
    endtask

    task automatic test_random();
        logic r, v, rr, c;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 45);
            step(r, v, 8'($urandom), rr, c);
            n_checks++;
            if (rd_valid !== m_rdv || rd_data !== m_rdd) begin
                n_errors++;
                $display("FAIL rand_read@%0d: got valid=%b data=%h want %b %h", i, rd_valid, rd_data, m_rdv, m_rdd);
            end
            n_checks++;
            if (count !== 4'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
                n_errors++;
                $display("FAIL rand_occ@%0d: got count=%0d empty=%b full=%b want %0d", i, count, empty, full, m_q.size());
            end
            n_checks++;
            if (overflow !== m_ovf || checksum !== m_sum) begin
                n_errors++;
                $display("FAIL rand_flags@%0d: got ovf=%b sum=%h want %b %h", i, overflow, checksum, m_ovf, m_sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_empty_rdwr();
        test_checksum_clr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 Parameter WIDTH, default 8, data width of the captured stream in bits.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; the block SHALL support only powers of two, minimum 2.
REQ-003 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 validi  input  1  producer strobe; the block SHALL treat data_in as a valid sample in every cycle where validi=1 (no backpressure).
REQ-006 data_in  input  WIDTH  sample captured when validi=1.
REQ-007 clr  input  1  synchronous soft clear of FIFO, flags and checksum.
REQ-008 rd_en  input  1  consumer read request.
REQ-009 rd_data  output  WIDTH  registered read data.
REQ-010 rd_valid  output  1  high for one cycle when rd_data holds a newly popped entry.
REQ-011 empty  output  1  high when count=0.
REQ-012 full  output  1  high when count=DEPTH.
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky flag: a sample was dropped.
REQ-015 checksum  output  WIDTH  running modulo-2^WIDTH sum of all accepted samples.

Function
REQ-016 The block SHALL store accepted samples in a circular FIFO with write and read pointers wrapping from DEPTH-1 to 0.
REQ-017 Occupancy FSM states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions SHALL follow count after each edge; empty/full SHALL decode the state.
REQ-018 Write accepted when validi=1 and (state!=FULL or pop occurs the same cycle).
REQ-019 validi=1 in FULL without a same-cycle pop: sample SHALL be dropped, overflow set to 1, pointers, count and checksum unchanged.
REQ-020 Pop occurs when rd_en=1 and state!=EMPTY; rd_en=1 in EMPTY SHALL be ignored (no pop, rd_valid=0), even if a write is accepted that same cycle.
REQ-021 Read latency: rd_data and rd_valid SHALL be valid in the cycle after the pop cycle; rd_data SHALL hold its value when no pop occurs.
REQ-022 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-023 checksum SHALL add data_in on every accepted write, wrapping modulo 2^WIDTH; dropped samples SHALL NOT be added.
REQ-024 overflow SHALL remain set until rst or clr.
REQ-025 clr=1 SHALL, at the next edge, zero pointers, count, overflow, checksum and rd_valid, and enter EMPTY; validi, data_in and rd_en SHALL be ignored in that cycle.
REQ-026 rst SHALL take priority over clr; clr SHALL take priority over all other inputs.

Reset
REQ-027 On rst=1 at a rising edge: rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, checksum=0, pointers=0, state EMPTY.
REQ-028 Reset mid-operation SHALL discard all stored entries; the first accepted sample after reset SHALL be returned by the first subsequent pop.
REQ-029 FIFO storage array SHALL NOT require reset.

Structure
REQ-030 A shared package result_capture_pkg SHALL hold the occupancy-state enum typedef (EMPTY, PARTIAL, FULL) and the default WIDTH/DEPTH constants.
REQ-031 Storage SHALL be one sub-module, capture_fifo_mem (registered read port, write-enable, address inputs); pointer, count, FSM, flag and checksum logic SHALL stay in result_capture.

Verification
REQ-032 After rst, write 0x11,0x22,0x33 on consecutive cycles, then rd_en for 3 cycles -> rd_data 0x11,0x22,0x33 with rd_valid each cycle after the pop; checksum=0x66; empty=1 at the end.
REQ-033 Write 8 samples 0x01..0x08 -> full=1, count=8; a 9th write 0xFF -> overflow=1, count=8, checksum=0x24; 8 pops return 0x01..0x08.
REQ-034 With FIFO full, validi=1 data 0xAA and rd_en=1 in the same cycle -> pop returns oldest entry, 0xAA accepted, count stays 8, overflow stays 0.
REQ-035 With FIFO empty, rd_en=1 with validi=1 data 0x5A -> rd_valid=0 next cycle, count=1; next rd_en returns 0x5A.
REQ-036 Write 0xF0 then 0x20 -> checksum=0x10 (wrap); assert clr with validi=1 -> count=0, checksum=0, overflow=0, sample ignored.
REQ-037 Fill with 5 entries, assert rst for one cycle, write 0x77, pop -> rd_data=0x77, all reset values as in REQ-027 in the cycle after rst.
